// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch queue.
// Latency: n/a (declarations only). Backpressure: n/a.
// Fetch FSM encoding, queue entry layout, PC step and reset address.
package fetch_pkg;

   localparam int unsigned INS_WIDTH        = 32;
   localparam logic [31:0] PC_STEP          = 32'd4;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   typedef enum logic [1:0] {
      RUN     = 2'd0,
      WAIT    = 2'd1,
      DISCARD = 2'd2
   } fetch_state_t;

   typedef struct packed {
      logic [INS_WIDTH-1:0] ins;
      logic [31:0]          pc;
   } fetch_entry_t;

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Generic DEPTH x WIDTH register FIFO with flush, registered head word and occupancy count.
// Latency: a push into an empty FIFO is visible at the head one cycle later.
// Backpressure: caller must only push with room (or with a same-cycle pop); pop when empty is ignored.
module fetch_fifo #(
   parameter int unsigned WIDTH = 64,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_dat,
   input  logic                     pop,
   input  logic                     flush,
   output logic                     head_vld,
   output logic [WIDTH-1:0]         head_dat,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] head_q, head_d;
   logic             do_push;
   logic             do_pop;

   assign do_pop  = pop && (cnt_q != '0);
   assign do_push = push && ((cnt_q < CW'(DEPTH)) || do_pop);

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      head_d   = head_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         cnt_d    = '0;
      end else begin
         if (do_push) begin
            mem_d[wr_ptr_q] = push_dat;
            wr_ptr_d        = wr_ptr_q + 1'b1;
         end
         if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
         end
         cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
         // The head register bypasses the array only when the pushed word becomes the head.
         if (cnt_d != '0) begin
            if (do_push && ((cnt_q - CW'(do_pop)) == '0)) begin
               head_d = push_dat;
            end else begin
               head_d = mem_q[rd_ptr_d];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         head_q   <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         head_q   <= head_d;
      end
   end

   assign head_vld = (cnt_q != '0);
   assign head_dat = head_q;
   assign count    = cnt_q;

endmodule

// File: rtl/ins_fetch_queue.sv
// Instruction fetch: PC, imem req/ack fetch, prefetch queue to decode; FETCH_PERF_EN adds perf counters.
// Latency: ack at edge N gives ins_valid after edge N; imem_req/imem_addr are purely registered.
// Backpressure: ins_ready low fills the queue, then fetching stops until a slot frees up.
module ins_fetch_queue
   import fetch_pkg::*;
#(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_data,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        ins_valid,
   output logic [31:0] ins_out,
   output logic [31:0] ins_pc,
   input  logic        ins_ready
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0] perf_fetched,
   output logic [31:0] perf_flushed
`endif
);

   localparam int unsigned CW = $clog2(DEPTH) + 1;

   fetch_state_t  state_q, state_d;
   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic          req_q, req_d;
   logic [31:0]   addr_q, addr_d;
   logic          ack_acc;
   logic          push;
   logic          pop;
   logic          flush;
   logic          drop;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_nxt;
   fetch_entry_t  push_ent;
   fetch_entry_t  head_ent;

   // Acks are only meaningful against our own outstanding request.
   assign ack_acc  = req_q && imem_ack;
   assign pop      = ins_valid && ins_ready;
   assign push_ent = '{ins: imem_data, pc: fetch_pc_q};

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      push       = 1'b0;
      flush      = 1'b0;
      drop       = 1'b0;
      if (redirect) begin
         flush      = 1'b1;
         fetch_pc_d = word_align(redirect_pc);
         drop       = ack_acc;
         state_d    = (req_q && !imem_ack) ? DISCARD : RUN;
      end else begin
         unique case (state_q)
            RUN, WAIT: begin
               if (req_q) begin
                  if (imem_ack) begin
                     push       = 1'b1;
                     fetch_pc_d = fetch_pc_q + PC_STEP;
                     state_d    = RUN;
                  end else begin
                     state_d = WAIT;
                  end
               end
            end
            DISCARD: begin
               if (ack_acc) begin
                  drop    = 1'b1;
                  state_d = RUN;
               end
            end
            default: state_d = RUN;
         endcase
      end

      cnt_nxt = flush ? '0 : (cnt + CW'(push) - CW'(pop));

      // The bus side is computed one cycle ahead so it never sees redirect/ack combinationally.
      if (state_d == RUN) begin
         req_d  = (cnt_nxt < CW'(DEPTH));
         addr_d = fetch_pc_d;
      end else begin
         req_d  = 1'b1;
         addr_d = addr_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= RUN;
         fetch_pc_q <= RESET_PC;
         req_q      <= 1'b0;
         addr_q     <= RESET_PC;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         req_q      <= req_d;
         addr_q     <= addr_d;
      end
   end

   fetch_fifo #(
      .WIDTH ($bits(fetch_entry_t)),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .push     (push),
      .push_dat (push_ent),
      .pop      (pop),
      .flush    (flush),
      .head_vld (ins_valid),
      .head_dat (head_ent),
      .count    (cnt)
   );

   assign imem_req  = req_q;
   assign imem_addr = addr_q;
   assign ins_out   = head_ent.ins;
   assign ins_pc    = head_ent.pc;

`ifdef FETCH_PERF_EN
   logic [31:0] perf_fetched_q, perf_fetched_d;
   logic [31:0] perf_flushed_q, perf_flushed_d;

   always_comb begin
      perf_fetched_d = perf_fetched_q + 32'(push);
      perf_flushed_d = perf_flushed_q + 32'(drop);
      // A head popped in the redirect cycle was delivered, not flushed.
      if (flush) begin
         perf_flushed_d = perf_flushed_d + 32'(cnt) - 32'(pop);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_fetched_q <= '0;
         perf_flushed_q <= '0;
      end else begin
         perf_fetched_q <= perf_fetched_d;
         perf_flushed_q <= perf_flushed_d;
      end
   end

   assign perf_fetched = perf_fetched_q;
   assign perf_flushed = perf_flushed_q;
`endif

endmodule

// File: tb/tb_ins_fetch_queue.sv
// Self-checking bench for ins_fetch_queue: directed scenarios plus randomized memory latency,
// decode stalls, redirects and mid-request resets, checked every cycle against a queue-level model.
module tb_ins_fetch_queue;

   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_data = '0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        ins_valid;
   logic [31:0] ins_out;
   logic [31:0] ins_pc;
   logic        ins_ready = 1'b0;
`ifdef FETCH_PERF_EN
   logic [31:0] perf_fetched;
   logic [31:0] perf_flushed;
`endif

   always #5 clk = ~clk;

   ins_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_data   (imem_data),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .ins_valid   (ins_valid),
      .ins_out     (ins_out),
      .ins_pc      (ins_pc),
      .ins_ready   (ins_ready)
`ifdef FETCH_PERF_EN
      ,
      .perf_fetched (perf_fetched),
      .perf_flushed (perf_flushed)
`endif
   );

   int n_cmp  = 0;
   int n_fail = 0;

   // Reference model: a queue of {ins,pc} plus one outstanding-request record.
   logic [63:0] mq[$];
   logic [31:0] m_fpc;
   bit          m_busy_req;
   bit          m_disc;
   bit          m_req;
   logic [31:0] m_addr;
   logic [31:0] m_fetched;
   logic [31:0] m_flushed;

   // Memory responder state and observation logs.
   bit          mem_busy;
   int          mem_lat;
   logic [31:0] alog[$];
   logic [31:0] deliv[$];
   int          n_acks;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_fpc      = RESET_PC;
      m_busy_req = 1'b0;
      m_disc     = 1'b0;
      m_req      = 1'b0;
      m_addr     = RESET_PC;
      m_fetched  = '0;
      m_flushed  = '0;
   endtask

   task automatic model_step(input bit ack, input logic [31:0] data, input bit redir,
                             input logic [31:0] rpc, input bit rdy);
      bit acked;
      acked = m_req && ack;
      if (mq.size() > 0 && rdy) void'(mq.pop_front());
      if (redir) begin
         m_flushed = m_flushed + mq.size();
         mq.delete();
         m_fpc = rpc & 32'hFFFF_FFFC;
         if (acked) begin
            m_flushed++;
            m_busy_req = 1'b0;
            m_disc     = 1'b0;
         end else if (m_req) begin
            m_busy_req = 1'b1;
            m_disc     = 1'b1;
         end else begin
            m_busy_req = 1'b0;
            m_disc     = 1'b0;
         end
      end else if (acked) begin
         if (m_disc) begin
            m_flushed++;
         end else begin
            mq.push_back({data, m_addr});
            m_fetched++;
            m_fpc = m_addr + 32'd4;
         end
         m_busy_req = 1'b0;
         m_disc     = 1'b0;
      end else if (m_req) begin
         m_busy_req = 1'b1;
      end
      if (!m_busy_req) begin
         m_req  = (mq.size() < DEPTH);
         m_addr = m_fpc;
      end
   endtask

   task automatic check_model();
      chk("imem_req", imem_req, m_req);
      if (m_req) chk("imem_addr", imem_addr, m_addr);
      chk("ins_valid", ins_valid, (mq.size() > 0));
      if (mq.size() > 0) begin
         chk("ins_out", ins_out, mq[0][63:32]);
         chk("ins_pc", ins_pc, mq[0][31:0]);
      end
`ifdef FETCH_PERF_EN
      chk("perf_fetched", perf_fetched, m_fetched);
      chk("perf_flushed", perf_flushed, m_flushed);
`endif
   endtask

   // One clock: drive inputs from the current outputs, advance the model, then compare after the edge.
   task automatic cycle(input int lat_sel, input int rdy_sel, input bit redir,
                        input logic [31:0] tgt, input bit ack_en);
      logic        a;
      logic [31:0] d;
      logic        r;
      a = 1'b0;
      d = $urandom;
      if (ack_en && imem_req) begin
         if (!mem_busy) begin
            mem_busy = 1'b1;
            mem_lat  = (lat_sel < 0) ? int'($urandom_range(0, 3)) : lat_sel;
         end
         if (mem_lat == 0) begin
            a        = 1'b1;
            mem_busy = 1'b0;
         end else begin
            mem_lat--;
         end
      end
      r = (rdy_sel == 2) ? ($urandom_range(0, 1) == 1) : rdy_sel[0];
      imem_ack    = a;
      imem_data   = d;
      redirect    = redir;
      redirect_pc = tgt;
      ins_ready   = r;
      if (imem_req) alog.push_back(imem_addr);
      if (ins_valid && r) deliv.push_back(ins_pc);
      if (imem_req && a) n_acks++;
      model_step(a, d, redir, tgt, r);
      @(posedge clk);
      #1;
      check_model();
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      imem_ack  = 1'b0;
      redirect  = 1'b0;
      ins_ready = 1'b0;
      #1;
      chk("rst_imem_req", imem_req, 1'b0);
      chk("rst_imem_addr", imem_addr, RESET_PC);
      chk("rst_ins_valid", ins_valid, 1'b0);
      chk("rst_ins_out", ins_out, 32'h0);
      chk("rst_ins_pc", ins_pc, 32'h0);
`ifdef FETCH_PERF_EN
      chk("rst_perf_fetched", perf_fetched, 32'h0);
      chk("rst_perf_flushed", perf_flushed, 32'h0);
`endif
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n    = 1'b1;
      mem_busy = 1'b0;
      mem_lat  = 0;
      n_acks   = 0;
      alog.delete();
      deliv.delete();
      model_reset();
   endtask

   initial begin
      logic [31:0] tgt;
      bit          redir;

      // Zero-wait streaming from reset.
      do_reset();
      repeat (5) cycle(0, 1, 0, 0, 1);
      chk("t1_nreq", alog.size(), 4);
      chk("t1_addr0", alog[0], 32'h0);
      chk("t1_addr1", alog[1], 32'h4);
      chk("t1_addr2", alog[2], 32'h8);
      chk("t1_addr3", alog[3], 32'hC);
      chk("t1_ndeliv", deliv.size(), 3);
      chk("t1_pc0", deliv[0], 32'h0);
      chk("t1_pc1", deliv[1], 32'h4);
      chk("t1_pc2", deliv[2], 32'h8);

      // Decode stalled: queue fills to DEPTH and fetching stops.
      do_reset();
      repeat (8) cycle(0, 0, 0, 0, 1);
      chk("t2_pushes", n_acks, 4);
      chk("t2_req_off", imem_req, 1'b0);
      alog.delete();
      deliv.delete();
      repeat (6) cycle(0, 1, 0, 0, 1);
      chk("t2_pc0", deliv[0], 32'h0);
      chk("t2_pc1", deliv[1], 32'h4);
      chk("t2_pc2", deliv[2], 32'h8);
      chk("t2_pc3", deliv[3], 32'hC);
      chk("t2_resume", alog[0], 32'h10);

      // Slow memory, redirect while waiting: late data discarded.
      do_reset();
      cycle(0, 1, 0, 0, 1);
      cycle(3, 1, 0, 0, 1);
      cycle(3, 1, 0, 0, 1);
      cycle(3, 1, 1, 32'h40, 1);
      chk("t3_hold_req", imem_req, 1'b1);
      chk("t3_hold_addr", imem_addr, 32'h0);
      cycle(3, 1, 0, 0, 1);
      chk("t3_req", imem_req, 1'b1);
      chk("t3_addr", imem_addr, 32'h40);
      chk("t3_novalid", ins_valid, 1'b0);
      cycle(0, 1, 0, 0, 1);
      chk("t3_valid", ins_valid, 1'b1);
      chk("t3_pc", ins_pc, 32'h40);

      // Redirect coinciding with ack and pop.
      do_reset();
      cycle(0, 1, 0, 0, 1);
      cycle(0, 1, 0, 0, 1);
      deliv.delete();
      cycle(0, 1, 1, 32'h103, 1);
      chk("t4_valid", ins_valid, 1'b0);
      chk("t4_req", imem_req, 1'b1);
      chk("t4_addr", imem_addr, 32'h100);
      chk("t4_ndeliv", deliv.size(), 1);
      chk("t4_deliv", deliv[0], 32'h0);

      // PC wrap at the top of the address space.
      do_reset();
      cycle(0, 1, 0, 0, 1);
      cycle(0, 1, 0, 0, 1);
      cycle(0, 1, 1, 32'hFFFF_FFFC, 1);
      chk("t5_addr_top", imem_addr, 32'hFFFF_FFFC);
      cycle(0, 1, 0, 0, 1);
      chk("t5_addr_wrap", imem_addr, 32'h0);
      chk("t5_valid", ins_valid, 1'b1);
      chk("t5_pc", ins_pc, 32'hFFFF_FFFC);

`ifdef FETCH_PERF_EN
      do_reset();
      repeat (4) cycle(0, 0, 0, 0, 1);
      cycle(0, 0, 1, 32'h200, 0);
      chk("t6_flushed", perf_flushed, 32'd3);
      chk("t6_fetched", perf_fetched, 32'd3);
      repeat (4) cycle(0, 1, 0, 0, 1);
`endif

      // Randomized traffic with occasional mid-request resets.
      do_reset();
      for (int i = 0; i < 2500; i++) begin
         redir = ($urandom_range(0, 31) == 0);
         tgt   = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                             : 32'($urandom);
         cycle(-1, 2, redir, tgt, 1);
         if ((i % 700) == 350) do_reset();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
